// File: rtl/alu_issue_rv.sv
// Issue/writeback stage in front of alu_rv: one OP/OP-IMM instruction in flight,
// operands from a 32x32 register file, result written back after ALU_LATENCY cycles.
module alu_issue_rv #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        enable,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] register_data_1,
  output logic [31:0] register_data_2,
  input  logic [31:0] register_data_out,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [2:0] WAIT_LAST = (ALU_LATENCY >= 2) ? 3'(ALU_LATENCY - 2) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_ILL} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic [31:0] ir;
  logic [31:0] rf [32];
  logic        accept, in_legal, busy, is_op, is_shift;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rdata_a, rdata_b;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  assign accept   = instr_valid & instr_ready;
  assign in_legal = (instruction[6:0] == OPC_OP) || (instruction[6:0] == OPC_IMM);
  assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WB);
  assign is_op    = (ir[6:0] == OPC_OP);
  // funct3 001/101 are the immediate shifts; they keep funct7 for SRLI/SRAI selection
  assign is_shift = !is_op && (ir[13:12] == 2'b01);

  assign rdata_a  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rdata_b  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE:  if (accept) state_nxt = in_legal ? S_ISSUE : S_ILL;
      S_ISSUE: begin
        wcnt_nxt  = 3'd0;
        state_nxt = (ALU_LATENCY == 1) ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == WAIT_LAST) state_nxt = S_WB;
        else                   wcnt_nxt  = wcnt + 3'd1;
      end
      S_WB:    state_nxt = S_IDLE;
      S_ILL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced to their reset values while reset is high, so a WB
  // coinciding with reset never retires.
  always_comb begin
    instr_ready     = 1'b0;
    enable          = 1'b0;
    funct3          = 3'd0;
    funct7          = 7'd0;
    register_data_1 = 32'd0;
    register_data_2 = 32'd0;
    retire_valid    = 1'b0;
    retire_rd       = 5'd0;
    retire_data     = 32'd0;
    illegal         = 1'b0;
    if (!reset) begin
      instr_ready = (state == S_IDLE);
      illegal     = (state == S_ILL);
      if (busy) begin
        enable          = (state == S_ISSUE);
        funct3          = ir[14:12];
        funct7          = (is_op || is_shift) ? ir[31:25] : 7'd0;
        register_data_1 = rdata_a;
        if (is_op)         register_data_2 = rdata_b;
        else if (is_shift) register_data_2 = {27'd0, ir[24:20]};
        else               register_data_2 = {{20{ir[31]}}, ir[31:20]};
      end
      if (state == S_WB) begin
        retire_valid = 1'b1;
        retire_rd    = rd;
        retire_data  = register_data_out;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
      ir    <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) ir <= instruction;
      if ((state == S_WB) && (rd != 5'd0)) rf[rd] <= register_data_out;
    end
  end
endmodule

// File: tb/tb_alu_issue_rv.sv
// Bench for alu_issue_rv: two instances (latency 1 and 3), a timed ALU model,
// and a register-file reference model checked on every issue and writeback.
module tb_alu_issue_rv;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] instruction;
  logic        vld [2];
  logic        rdy [2], en [2], rv [2], ill [2];
  logic [2:0]  f3 [2];
  logic [6:0]  f7 [2];
  logic [31:0] op1 [2], op2 [2], aout [2], rdata [2], dbgd [2];
  logic [4:0]  rrd [2], dbga [2];
  logic [31:0] mrf [2][32];
  int checks = 0, errors = 0;

  alu_issue_rv #(.ALU_LATENCY(1)) u0 (
    .clock(clock), .reset(reset), .instr_valid(vld[0]), .instr_ready(rdy[0]),
    .instruction(instruction), .enable(en[0]), .funct3(f3[0]), .funct7(f7[0]),
    .register_data_1(op1[0]), .register_data_2(op2[0]), .register_data_out(aout[0]),
    .retire_valid(rv[0]), .retire_rd(rrd[0]), .retire_data(rdata[0]), .illegal(ill[0]),
    .dbg_addr(dbga[0]), .dbg_data(dbgd[0]));

  alu_issue_rv #(.ALU_LATENCY(3)) u1 (
    .clock(clock), .reset(reset), .instr_valid(vld[1]), .instr_ready(rdy[1]),
    .instruction(instruction), .enable(en[1]), .funct3(f3[1]), .funct7(f7[1]),
    .register_data_1(op1[1]), .register_data_2(op2[1]), .register_data_out(aout[1]),
    .retire_valid(rv[1]), .retire_rd(rrd[1]), .retire_data(rdata[1]), .illegal(ill[1]),
    .dbg_addr(dbga[1]), .dbg_data(dbgd[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] fn3, input logic [6:0] fn7,
                                      input logic [31:0] a, input logic [31:0] b);
    case (fn3)
      3'd0:    return fn7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return fn7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-in: result is only presented in the exact cycle ALU_LATENCY after enable
  for (genvar g = 0; g < 2; g++) begin : g_alu
    int          cnt  = 0;
    logic        live = 1'b0;
    logic [31:0] res  = 32'd0;
    always @(posedge clock) begin
      if (en[g]) begin
        res  <= alu(f3[g], f7[g], op1[g], op2[g]);
        cnt  <= lat(g) - 1;
        live <= 1'b1;
      end else if (cnt > 0) cnt <= cnt - 1;
      else live <= 1'b0;
    end
    assign aout[g] = (live && cnt == 0) ? res : (32'hBAD0BAD0 ^ g);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dbg_chk(input int d, input logic [4:0] a, input logic [31:0] exp, input string tag);
    dbga[d] = a;
    #1;
    chk(tag, dbgd[d], exp);
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!rdy[d] && n < 20) begin step(); n++; end
    chk("ready_wait", 32'(rdy[d]), 32'd1);
  endtask

  // Send one instruction and check every cycle until the block is idle again.
  task automatic exec(input int d, input logic [31:0] ins, input bit poke);
    logic [6:0]  opc;
    logic [2:0]  ef3;
    logic [6:0]  ef7;
    logic [4:0]  erd;
    logic [31:0] ea, eb, eres;
    opc = ins[6:0];
    ef3 = ins[14:12];
    erd = ins[11:7];
    wait_ready(d);
    instruction = ins;
    vld[d] = 1'b1;
    step();
    vld[d] = 1'b0;
    instruction = $urandom;
    if (opc != OPC_OP && opc != OPC_IMM) begin
      chk("ill_pulse", 32'(ill[d]), 32'd1);
      chk("ill_no_en", 32'(en[d]), 32'd0);
      chk("ill_no_rv", 32'(rv[d]), 32'd0);
      step();
      chk("ill_clear", 32'(ill[d]), 32'd0);
      chk("ill_ready", 32'(rdy[d]), 32'd1);
      chk("ill_no_rv2", 32'(rv[d]), 32'd0);
      chk("ill_no_en2", 32'(en[d]), 32'd0);
      return;
    end
    ea = mrf[d][ins[19:15]];
    if (opc == OPC_OP) begin
      eb  = mrf[d][ins[24:20]];
      ef7 = ins[31:25];
    end else if (ef3 == 3'd1 || ef3 == 3'd5) begin
      eb  = {27'd0, ins[24:20]};
      ef7 = ins[31:25];
    end else begin
      eb  = 32'($signed(ins[31:20]));
      ef7 = 7'd0;
    end
    eres = alu(ef3, ef7, ea, eb);
    chk("issue_en", 32'(en[d]), 32'd1);
    chk("issue_f3", 32'(f3[d]), 32'(ef3));
    chk("issue_f7", 32'(f7[d]), 32'(ef7));
    chk("issue_op1", op1[d], ea);
    chk("issue_op2", op2[d], eb);
    chk("issue_no_rv", 32'(rv[d]), 32'd0);
    if (poke) begin
      vld[d] = 1'b1;
      instruction = 32'h0000006F;
    end
    for (int c = 2; c <= lat(d); c++) begin
      step();
      chk("wait_en", 32'(en[d]), 32'd0);
      chk("wait_op1", op1[d], ea);
      chk("wait_op2", op2[d], eb);
      chk("wait_f7", 32'(f7[d]), 32'(ef7));
      chk("wait_no_rv", 32'(rv[d]), 32'd0);
      chk("wait_no_ready", 32'(rdy[d]), 32'd0);
    end
    step();
    vld[d] = 1'b0;
    chk("wb_rv", 32'(rv[d]), 32'd1);
    chk("wb_rd", 32'(rrd[d]), 32'(erd));
    chk("wb_data", rdata[d], eres);
    chk("wb_op1", op1[d], ea);
    chk("wb_op2", op2[d], eb);
    chk("wb_f3", 32'(f3[d]), 32'(ef3));
    if (erd != 5'd0) mrf[d][erd] = eres;
    step();
    chk("idle_ready", 32'(rdy[d]), 32'd1);
    chk("idle_no_rv", 32'(rv[d]), 32'd0);
    chk("idle_op1", op1[d], 32'd0);
    chk("idle_op2", op2[d], 32'd0);
    chk("idle_f7", 32'(f7[d]), 32'd0);
    chk("idle_no_ill", 32'(ill[d]), 32'd0);
    dbg_chk(d, erd, mrf[d][erd], "dbg_rd");
  endtask

  task automatic sweep(input string tag);
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        @(negedge clock);
        dbg_chk(d, 5'(r), mrf[d][r], tag);
      end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      w[6:0] = OPC_OP;
    else if (k < 9) w[6:0] = OPC_IMM;
    else if (w[6:0] == OPC_OP || w[6:0] == OPC_IMM) w[6:0] = w[6:0] ^ 7'b0000100;
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    instruction = 32'd0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0;
      dbga[d] = 5'd0;
      for (int r = 0; r < 32; r++) mrf[d][r] = 32'd0;
    end

    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(rdy[d]), 32'd0);
      chk("rst_en", 32'(en[d]), 32'd0);
      chk("rst_rv", 32'(rv[d]), 32'd0);
      chk("rst_ill", 32'(ill[d]), 32'd0);
      chk("rst_op2", op2[d], 32'd0);
    end
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(rdy[0]), 32'd1);
    chk("post_rst_ready1", 32'(rdy[1]), 32'd1);

    // directed program on both latencies
    for (int d = 0; d < 2; d++) begin
      exec(d, 32'h00500093, 1'b0);            // ADDI x1,x0,5
      dbg_chk(d, 5'd1, 32'd5, "x1_is_5");
      exec(d, 32'h00700113, 1'b1);            // ADDI x2,x0,7
      exec(d, 32'h002081B3, 1'b0);            // ADD x3,x1,x2
      dbg_chk(d, 5'd3, 32'd12, "x3_is_12");
      exec(d, 32'hFFF00293, 1'b0);            // ADDI x5,x0,-1
      dbg_chk(d, 5'd5, 32'hFFFFFFFF, "x5_is_m1");
      exec(d, 32'h4020D213, 1'b0);            // SRAI x4,x1,2
      dbg_chk(d, 5'd4, 32'd1, "x4_is_1");
      exec(d, 32'h00900013, 1'b0);            // ADDI x0,x0,9
      dbg_chk(d, 5'd0, 32'd0, "x0_is_0");
      exec(d, 32'h0000006F, 1'b0);            // JAL -> illegal
    end

    for (int i = 0; i < 160; i++)
      exec($urandom_range(0, 1), rand_ins(), 1'($urandom_range(0, 1)));
    sweep("dbg_sweep");

    // reset while the latency-3 instance sits in WAIT
    wait_ready(1);
    instruction = 32'h00300313;               // ADDI x6,x0,3
    vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    chk("mid_issue_en", 32'(en[1]), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rdy[1]), 32'd0);
    chk("mid_rst_rv", 32'(rv[1]), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_after_ready", 32'(rdy[1]), 32'd1);
    chk("mid_after_op1", op1[1], 32'd0);
    chk("mid_after_en", 32'(en[1]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_no_retire", 32'(rv[1]), 32'd0);
    end
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) mrf[d][r] = 32'd0;
    dbg_chk(1, 5'd6, 32'd0, "mid_x6_zero");
    sweep("rst_sweep");
    exec(1, 32'h00300313, 1'b0);
    dbg_chk(1, 5'd6, 32'd3, "x6_after_rst");
    exec(0, 32'h002081B3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_rv.md
# alu_issue_rv

Issue/writeback stage directly upstream of `alu_rv`. It accepts one RV32I OP or OP-IMM instruction at a time over a valid/ready handshake and reads operands from an internal 32x32 register file. It drives the ALU's `enable`, `funct3`, `funct7`, `register_data_1` and `register_data_2`, then captures `register_data_out` after the ALU latency and writes it back to `rd`.

## Interface
- `ALU_LATENCY`, 1: cycles from the `enable` cycle to valid `register_data_out`; legal range 1..7.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: `instruction` is valid.
- `instr_ready` out 1: block can accept an instruction.
- `instruction` in 32: RV32I instruction word.
- `enable` out 1: ALU enable, one-cycle pulse per legal instruction.
- `funct3` out 3: to ALU.
- `funct7` out 7: to ALU.
- `register_data_1` out 32: operand A, x[rs1].
- `register_data_2` out 32: operand B, x[rs2] or immediate.
- `register_data_out` in 32: ALU result.
- `retire_valid` out 1: one-cycle pulse at writeback.
- `retire_rd` out 5: destination register of the retiring instruction.
- `retire_data` out 32: value written back.
- `illegal` out 1: one-cycle pulse for an unsupported opcode.
- `dbg_addr` in 5: debug read address.
- `dbg_data` out 32: combinational x[`dbg_addr`]; reads 0 for x0.

## Operation
- States:
  - IDLE: `instr_ready`=1.
  - ISSUE: `enable`=1.
  - WAIT: runs `ALU_LATENCY`-1 cycles; skipped when `ALU_LATENCY`=1.
  - WB.
  - ILL.
- Handshake:
  - Transfer occurs when `instr_valid` & `instr_ready`; the instruction is latched.
  - `instr_ready` = (state==IDLE) & !`reset`.
- Opcode 0110011 (OP):
  - `register_data_2` = x[rs2].
  - `funct7` = instr[31:25].
  - `funct3` = instr[14:12].
- Opcode 0010011 (OP-IMM):
  - funct3 001/101 (shifts): `register_data_2` = zero-extended instr[24:20]; `funct7` = instr[31:25].
  - Other funct3: `register_data_2` = sign-extended instr[31:20]; `funct7` = 0000000.
- Any other opcode: IDLE -> ILL. ILL pulses `illegal`, produces no enable and no write, then returns to IDLE.
- Transitions:
  - IDLE -> ISSUE (legal) or ILL.
  - ISSUE -> WAIT, or ISSUE -> WB when `ALU_LATENCY`=1.
  - WAIT -> WB after its count.
  - WB -> IDLE.
- Operands, `funct3` and `funct7` are held stable from ISSUE through WB.
- Outside ISSUE..WB, operands and functs are 0.
- WB: `retire_valid`=1, `retire_rd`=rd, `retire_data`=`register_data_out`. x[rd] is written at the end of WB unless rd=0.
- x0 is never written and always reads 0.
- No hazard logic is needed: execution is strictly one instruction at a time, and writeback completes before the next read.

## Timing
- Reset values:
  - State IDLE.
  - All register-file entries 0.
  - `instr_ready`=0 during reset.
  - `enable`, `funct3`, `funct7`, `register_data_1`, `register_data_2`, `retire_valid`, `retire_rd`, `retire_data` and `illegal` all 0.
- With acceptance at cycle 0:
  - ISSUE is cycle 1.
  - WB is cycle 1+`ALU_LATENCY`.
  - `instr_ready` reasserts at cycle 2+`ALU_LATENCY`.
- Throughput is one instruction per 2+`ALU_LATENCY` cycles.
- Illegal instruction:
  - `illegal` is high in cycle 1.
  - `instr_ready` reasserts in cycle 2.
- `register_data_out` is sampled only in WB.
- Reset asserted in any state:
  - The next cycle is IDLE with all outputs at reset values.
  - An in-flight instruction is discarded with no retire and no write.
  - Register file cleared.
- `instr_valid` while not ready: ignored; the instruction is not latched.

## Test plan
- ADDI `ALU_LATENCY`=1: reset, then send 0x00500093 (ADDI x1,x0,5) at cycle 0 with a real `alu_rv` attached.
  - Cycle 1: `enable`=1, `register_data_1`=0, `register_data_2`=5, `funct3`=000.
  - Cycle 2: `retire_valid`=1, `retire_rd`=1, `retire_data`=5.
  - `dbg_data`(x1)=5.
- ADD: with x1=5, x2=7, send 0x002081B3 (ADD x3,x1,x2).
  - `register_data_1`=5, `register_data_2`=7, `funct7`=0.
  - Retire x3=12.
- Immediate corner cases:
  - ADDI x5,x0,-1 (0xFFF00293): `register_data_2`=0xFFFFFFFF.
  - SRAI x4,x1,2 (0x4020D213): `register_data_2`=0x00000002, `funct7`=0100000.
- x0 write: ADDI x0,x0,9 -> `retire_valid`=1 with `retire_rd`=0, `dbg_data`(x0)=0.
- Illegal: send 0x0000006F (JAL).
  - `illegal`=1 at cycle 1; `enable` never asserts; no retire.
  - `instr_ready`=1 at cycle 2.
- Reset mid-operation, `ALU_LATENCY`=3:
  - Accept ADDI x6,x0,3, then assert `reset` at cycle 2 (WAIT).
  - No `retire_valid`; x6=0.
  - `instr_ready`=1 the cycle after `reset` deasserts.
